// File: rtl/cic_interpolator.sv
// cic_interpolator: three-stage CIC interpolator, R = 2**LOG2R, 16-bit signed audio in and out.
// Optional macro CIC_INT_ROUND_EN: round-half-up plus positive clamp in the output stage.

module cic_interpolator #(
   parameter int LOG2R = 3,
   parameter int M     = 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               OUT_TICK,
   input  logic signed [15:0] AUD_IN,
   input  logic               IN_VALID,
   output logic               IN_READY,
   output logic signed [15:0] AUD_OUT,
   output logic               OUT_VALID,
   output logic               UNDERRUN
);

   localparam int G = 2*LOG2R + 3*(M-1);
   localparam int W = 16 + G;

   genvar gi;

   logic [LOG2R-1:0] r_phase;
   logic             r_full;
   logic [15:0]      r_hold;
   logic             r_underrun;
   logic [15:0]      r_aud_out;
   logic             r_out_valid;

   logic             w_slot;
   logic             w_take_hold;
   logic             w_bypass;
   logic             w_load;
   logic [W-1:0]     w_comb_in;
   logic [W-1:0]     w_comb [4];
   logic [W-1:0]     w_int_in;
   logic [W-1:0]     w_int_src [3];
   logic [W-1:0]     r_int [3];
   logic [15:0]      w_out;

   // A sample slot is the OUT_TICK that lands on phase 0.
   assign w_slot      = OUT_TICK && (r_phase == '0);
   assign w_take_hold = w_slot && r_full;
   assign w_bypass    = w_slot && !r_full && IN_VALID;
   assign IN_READY    = !RST && !r_full;
   assign w_load      = IN_VALID && IN_READY && !w_bypass;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_phase    <= '0;
         r_full     <= 1'b0;
         r_hold     <= '0;
         r_underrun <= 1'b0;
      end else begin
         if (OUT_TICK) begin
            r_phase <= r_phase + LOG2R'(1);
         end
         if (w_load) begin
            r_full <= 1'b1;
            r_hold <= AUD_IN;
         end else if (w_take_hold) begin
            r_full <= 1'b0;
         end
         if (w_slot && !r_full && !IN_VALID) begin
            r_underrun <= 1'b1;
         end
      end
   end

   always_comb begin
      w_comb_in = '0;
      if (w_take_hold) begin
         w_comb_in = {{G{r_hold[15]}}, r_hold};
      end else if (w_bypass) begin
         w_comb_in = {{G{AUD_IN[15]}}, AUD_IN};
      end
   end

   // Comb chain is combinational; only the M-deep delay lines are state, advanced once per slot.
   assign w_comb[0] = w_comb_in;

   for (gi = 0; gi < 3; gi++) begin : g_comb
      logic [W-1:0] r_dly [M];

      assign w_comb[gi+1] = w_comb[gi] - r_dly[M-1];

      always_ff @(posedge CLK) begin
         if (RST) begin
            for (int j = 0; j < M; j++) begin
               r_dly[j] <= '0;
            end
         end else if (w_slot) begin
            r_dly[0] <= w_comb[gi];
            for (int j = 1; j < M; j++) begin
               r_dly[j] <= r_dly[j-1];
            end
         end
      end
   end

   // Zero stuffing: the integrators see the comb output only on the slot tick.
   assign w_int_in     = w_slot ? w_comb[3] : '0;
   assign w_int_src[0] = w_int_in;

   for (gi = 1; gi < 3; gi++) begin : g_int_src
      assign w_int_src[gi] = r_int[gi-1];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 3; i++) begin
            r_int[i] <= '0;
         end
      end else if (OUT_TICK) begin
         for (int i = 0; i < 3; i++) begin
            r_int[i] <= r_int[i] + w_int_src[i];
         end
      end
   end

`ifdef CIC_INT_ROUND_EN
   localparam logic [W:0]        RND_BIAS = {{(W+1-G){1'b0}}, 1'b1, {(G-1){1'b0}}};
   localparam logic signed [W:0] OUT_MAX  = {{(W+1-16){1'b0}}, 16'h7FFF};

   logic signed [W:0] w_biased;
   logic signed [W:0] w_shifted;

   // One guard bit so the bias cannot wrap a large positive I3 negative.
   assign w_biased  = $signed({r_int[2][W-1], r_int[2]}) + $signed(RND_BIAS);
   assign w_shifted = w_biased >>> G;
   assign w_out     = (w_shifted > OUT_MAX) ? 16'h7FFF : w_shifted[15:0];
`else
   assign w_out = r_int[2][G+15:G];
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_aud_out   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= OUT_TICK;
         if (OUT_TICK) begin
            r_aud_out <= w_out;
         end
      end
   end

   assign AUD_OUT   = r_aud_out;
   assign OUT_VALID = r_out_valid;
   assign UNDERRUN  = r_underrun;

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed checks of cic_interpolator (R=8, M=1) with hand-computed expectations.
// Expectations follow CIC_INT_ROUND_EN when it is defined for the build.

module tb_cic_interpolator;

`ifdef CIC_INT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               OUT_TICK = 1'b0;
   logic signed [15:0] AUD_IN = '0;
   logic               IN_VALID = 1'b0;
   logic               IN_READY;
   logic signed [15:0] AUD_OUT;
   logic               OUT_VALID;
   logic               UNDERRUN;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;

   logic signed [15:0] last_out;
   logic               last_ov;
   logic               last_ov_idle;

   // Impulse response of three cascaded length-8 boxcars (sum 512, peak 48).
   int H [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                  48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

   always #5 CLK = ~CLK;

   cic_interpolator #(.LOG2R(3), .M(1)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .OUT_TICK  (OUT_TICK),
      .AUD_IN    (AUD_IN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .AUD_OUT   (AUD_OUT),
      .OUT_VALID (OUT_VALID),
      .UNDERRUN  (UNDERRUN)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One CLK cycle: drive inputs, count a handshake if one happens at the coming edge.
   task automatic step(input logic t, input logic v, input logic signed [15:0] d);
      OUT_TICK = t;
      IN_VALID = v;
      AUD_IN   = d;
      #1;
      if (IN_VALID && IN_READY) hs_cnt++;
      @(negedge CLK);
      OUT_TICK = 1'b0;
   endtask

   // One output tick followed by three idle cycles (OUT_TICK every 4 CLK).
   task automatic tick_slot(input logic v, input logic signed [15:0] d, input logic keep);
      step(1'b1, v, d);
      last_out = AUD_OUT;
      last_ov  = OUT_VALID;
      $display("[TB] tick in_valid=%0b in=%0d out=%0d out_valid=%0b underrun=%0b",
               v, d, AUD_OUT, OUT_VALID, UNDERRUN);
      step(1'b0, keep, d);
      last_ov_idle = OUT_VALID;
      step(1'b0, keep, d);
      step(1'b0, keep, d);
   endtask

   task automatic do_reset(input int n, input logic busy);
      RST      = 1'b1;
      OUT_TICK = busy;
      IN_VALID = busy;
      AUD_IN   = 16'sd777;
      #1;
      chk("ready_in_reset", IN_READY, 0);
      repeat (n) @(negedge CLK);
      RST      = 1'b0;
      OUT_TICK = 1'b0;
      IN_VALID = 1'b0;
      AUD_IN   = '0;
      #1;
   endtask

   // Bypass-fed impulse of 64 from phase 0: AUD_OUT on tick k equals H[k-3].
   task automatic run_impulse(input string tag);
      int sum = 0;
      int exp;
      hs_cnt = 0;
      for (int k = 0; k < 31; k++) begin
         tick_slot((k % 8) == 0, (k == 0) ? 16'sd64 : 16'sd0, 1'b0);
         exp = 0;
         if (k >= 3 && k < 25) exp = H[k-3];
         chk($sformatf("%s_k%0d", tag, k), last_out, exp);
         sum += int'(last_out);
      end
      chk({tag, "_sum"}, sum, 512);
      chk({tag, "_handshakes"}, hs_cnt, 4);
      chk({tag, "_underrun"}, UNDERRUN, 0);
      chk({tag, "_ready"}, IN_READY, 1);
      chk({tag, "_ov_on_tick"}, last_ov, 1);
      chk({tag, "_ov_idle"}, last_ov_idle, 0);
   endtask

   // DC input every slot; partial sum 63/64 at tick 16, unity from tick 24 on.
   task automatic run_dc(input logic signed [15:0] val, input int exp16);
      do_reset(1, 1'b0);
      for (int k = 0; k < 40; k++) begin
         tick_slot((k % 8) == 0, val, 1'b0);
         if (k == 16) chk($sformatf("dc%0d_k16", val), last_out, exp16);
         if (k >= 24) chk($sformatf("dc%0d_k%0d", val, k), last_out, int'(val));
      end
      chk($sformatf("dc%0d_underrun", val), UNDERRUN, 0);
   endtask

   initial begin
      // Power-up reset
      do_reset(2, 1'b0);
      chk("rst_aud_out", AUD_OUT, 0);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_underrun", UNDERRUN, 0);
      chk("rst_ready_after", IN_READY, 1);

      run_impulse("imp");

      run_dc(16'sd1000, 984);
      run_dc(-16'sd1000, RND ? -984 : -985);

      // Flow control through the hold register, IN_VALID held high
      do_reset(1, 1'b0);
      hs_cnt = 0;
      step(1'b0, 1'b1, 16'sd500);
      step(1'b0, 1'b1, 16'sd500);
      step(1'b0, 1'b1, 16'sd500);
      chk("flow_preload_hs", hs_cnt, 1);
      chk("flow_full_ready", IN_READY, 0);
      hs_cnt = 0;
      for (int k = 0; k < 80; k++) begin
         tick_slot(1'b1, 16'sd500, 1'b1);
         if (k == 40) chk("flow_out_k40", last_out, 500);
      end
      chk("flow_handshakes", hs_cnt, 10);
      chk("flow_underrun", UNDERRUN, 0);

      // Underrun: slot 0 with no input, then input resumes
      do_reset(1, 1'b0);
      chk("ur_before", UNDERRUN, 0);
      step(1'b1, 1'b0, 16'sd0);
      chk("ur_set", UNDERRUN, 1);
      step(1'b0, 1'b0, 16'sd0);
      step(1'b0, 1'b0, 16'sd0);
      step(1'b0, 1'b0, 16'sd0);
      for (int k = 1; k <= 16; k++) begin
         tick_slot((k % 8) == 0, 16'sd1000, 1'b0);
      end
      chk("ur_sticky", UNDERRUN, 1);
      chk("ur_pre_reset_out", last_out, 328);

      // Mid-stream reset with a tick and a handshake offered during it
      do_reset(2, 1'b1);
      chk("mid_rst_aud_out", AUD_OUT, 0);
      chk("mid_rst_out_valid", OUT_VALID, 0);
      chk("mid_rst_underrun", UNDERRUN, 0);
      chk("mid_rst_ready", IN_READY, 1);
      run_impulse("imp_after_rst");

      // Rounding on a small impulse
      do_reset(1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick_slot((k % 8) == 0, (k == 0) ? 16'sd32 : 16'sd0, 1'b0);
         if (k == 3) chk("rnd_k3", last_out, RND ? 1 : 0);
         if (k == 4) chk("rnd_k4", last_out, RND ? 2 : 1);
      end

      // Full-scale DC must not wrap negative
      run_dc(16'sd32767, 32255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Three-stage CIC interpolation filter: the upsampling counterpart of the audio-path CIC decimator. It accepts 16-bit signed audio samples at the low (frame) rate and emits 16-bit signed samples at R times that rate, one per output tick. It sits between the sample source (deserializer or DSP stage) and the high-rate consumer (serializer or DAC feed), with a ready/valid input and a strobe-paced output.

## Interface
- LOG2R, 3: log2 of the interpolation factor R (R = 8 default); legal 1..5.
- M, 1: comb differential delay; legal 1 or 2.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- OUT_TICK  in  1  one-cycle pulse at the high output rate; at most one per cycle.
- AUD_IN  in  16  signed input sample.
- IN_VALID  in  1  AUD_IN holds a valid sample.
- IN_READY  out  1  block can take a sample this cycle.
- AUD_OUT  out  16  signed output sample.
- OUT_VALID  out  1  one-cycle pulse: AUD_OUT updated this cycle.
- UNDERRUN  out  1  sticky: a phase-0 tick found no input sample.

## Operation
- Reset (RST high at an edge): all integrators, comb delay lines, hold register, phase counter, AUD_OUT, OUT_VALID, UNDERRUN cleared to 0; IN_READY reads 0 while RST is high, 1 on the first cycle after.
- Input holding register, one entry: IN_READY = not full. IN_VALID && IN_READY loads AUD_IN.
- Phase counter 0..R-1 advances on each OUT_TICK, wraps R-1 -> 0.
- On OUT_TICK with phase 0 (sample slot):
  - Hold full: its sample is consumed; hold becomes empty unless refilled in the same cycle.
  - Hold empty and IN_VALID high in that same cycle: AUD_IN consumed directly (bypass); hold stays empty.
  - Neither: comb input is 0, UNDERRUN set to 1 and held until reset.
  - Combs run once: three cascaded combs y = x - x[n-M], delay lines advance one sample.
- Integrator input: comb-3 output on the phase-0 tick, 0 on all other ticks (zero stuffing).
- Integrators, on every OUT_TICK, registered cascade using pre-tick values: I1 <= I1 + x; I2 <= I2 + I1; I3 <= I3 + I2.
- Output, on every OUT_TICK: AUD_OUT <= I3 arithmetic-shifted right by G, bits [15:0]; OUT_VALID <= 1, else 0.
- Widths: G = 2*LOG2R + 3*(M-1); all comb and integrator registers are W = 16 + G bits, two's complement, modular wrap-around (no saturation internally; required for CIC correctness). DC gain after the shift is exactly 1.

## Timing
- A sample consumed on tick t first reaches I1 at t, I2 at t+1, I3 at t+2, and AUD_OUT on tick t+3 (counting OUT_TICKs). Visible one CLK cycle after that tick, with OUT_VALID.
- Input throughput: exactly one sample per R ticks. With IN_VALID held high, a new sample is loaded the cycle after each consumption.
- OUT_TICK absent: no state changes except hold-register loading.
- RST asserted mid-stream overrides any simultaneous OUT_TICK or input handshake. The next stream restarts at phase 0.

## Configuration
- CIC_INT_ROUND_EN defined: the output stage adds 2^(G-1) to I3 before the shift (round half up), and clamps results above 32767 to 16'h7FFF.
- Undefined: plain truncating arithmetic shift, no clamp.

## Test plan
- Reset: drive RST for 2 cycles mid-stream -> AUD_OUT=0, OUT_VALID=0, UNDERRUN=0, phase 0. IN_READY=0 during reset, 1 on the cycle after.
- DC: AUD_IN=1000 every slot, OUT_TICK every 4 CLK -> after 3*R ticks, AUD_OUT=1000 on every tick. Repeat with -1000 -> -1000.
- Impulse (defaults): one sample 64, then zeros -> AUD_OUT nonzero run 1,3,6,10,15,21,28,36,..., peak 48 at positions 11 and 12. Sum over run = 512, then returns to 0.
- Flow control: IN_VALID held high, 80 ticks -> exactly 10 handshakes, one per 8 ticks. Bypass case (hold empty, IN_VALID rises on the phase-0 tick) consumes the same-cycle sample.
- Underrun: withhold input at one phase-0 tick -> UNDERRUN=1 from the next cycle, stays 1 after input resumes, clears only on RST.
- Rounding: impulse of 32 -> first output 0 without CIC_INT_ROUND_EN, 1 with it. DC 32767 with macro -> AUD_OUT=32767, no wrap to negative.
